// File: rtl/captura_teclas.sv
// captura_teclas: keypad capture for a hex calculator.
// Turns select-button presses on the key under the cursor into operands
// and operations, and runs one req/ack transaction with the ALU per
// computation. It also holds the value shown on the display.
// Optional build macro RESULT_CHAIN_EN: when defined, an operator or root
// pressed on a shown result starts the next operation from that result.
module captura_teclas #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            Pos,
    input  logic                  BS,
    input  logic [4*DIGITS-1:0]   result,
    input  logic                  calc_ack,
    input  logic                  calc_err,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic [2:0]            op_sel,
    output logic                  calc_req,
    output logic [4*DIGITS-1:0]   disp_val,
    output logic                  err,
    output logic [1:0]            estado
);

    localparam int W  = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);

    // Key codes for the non-digit keys
    localparam logic [4:0] K_EQ   = 5'd4;
    localparam logic [4:0] K_ROOT = 5'd9;
    localparam logic [4:0] K_BSP  = 5'd14;
    localparam logic [4:0] K_AC   = 5'd19;
    localparam logic [4:0] K_CE   = 5'd24;

    localparam logic [2:0] OP_ROOT = 3'd4;

    typedef enum logic [1:0] {
        ENT_A  = 2'd0,
        ENT_B  = 2'd1,
        ESPERA = 2'd2,
        RESULT = 2'd3
    } estado_t;

    estado_t        state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic [NW-1:0]  n_q, n_d;
    logic [2:0]     op_sel_q, op_sel_d;
    logic           err_q, err_d;
    logic           bs_q, bs_d;

    logic           sel;
    logic           is_dig;
    logic [3:0]     dig;
    logic           is_op;
    logic [W-1:0]   dig_w;
    logic [W-1:0]   opnd;

    // Key code to hex digit; the map follows the physical keypad layout
    always_comb begin
        is_dig = 1'b1;
        dig    = 4'h0;
        case (Pos)
            5'd20: dig = 4'h0;
            5'd21: dig = 4'h1;
            5'd22: dig = 4'h2;
            5'd23: dig = 4'h3;
            5'd15: dig = 4'h4;
            5'd16: dig = 4'h5;
            5'd17: dig = 4'h6;
            5'd18: dig = 4'h7;
            5'd10: dig = 4'h8;
            5'd11: dig = 4'h9;
            5'd12: dig = 4'hA;
            5'd13: dig = 4'hB;
            5'd5:  dig = 4'hC;
            5'd6:  dig = 4'hD;
            5'd7:  dig = 4'hE;
            5'd8:  dig = 4'hF;
            default: is_dig = 1'b0;
        endcase
        is_op = (Pos <= 5'd3);
        dig_w = {{(W-4){1'b0}}, dig};
    end

    // Next-state and datapath: one key action per rising edge of BS
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        n_d      = n_q;
        op_sel_d = op_sel_q;
        err_d    = err_q;
        bs_d     = BS;
        sel      = BS & ~bs_q;
        opnd     = (state_q == ENT_B) ? b_q : a_q;

        if (sel && Pos == K_AC) begin
            // AC beats everything, including a same-cycle ack
            state_d  = ENT_A;
            a_d      = '0;
            b_d      = '0;
            res_d    = '0;
            n_d      = '0;
            op_sel_d = '0;
            err_d    = 1'b0;
        end else if (state_q == ESPERA) begin
            // Only the ALU can move us on; other keys are dropped here
            if (calc_ack) begin
                res_d   = result;
                err_d   = calc_err;
                state_d = RESULT;
            end
        end else if (sel) begin
            case (state_q)
                ENT_A, ENT_B: begin
                    // Editing of the active operand; n counts only its digits
                    if (is_dig) begin
                        if (n_q < NW'(DIGITS)) begin
                            opnd = (opnd << 4) | dig_w;
                            n_d  = n_q + 1'b1;
                        end
                    end else if (Pos == K_BSP) begin
                        if (n_q != '0) begin
                            opnd = opnd >> 4;
                            n_d  = n_q - 1'b1;
                        end
                    end else if (Pos == K_CE) begin
                        opnd = '0;
                        n_d  = '0;
                    end
                    if (state_q == ENT_A) a_d = opnd;
                    else                  b_d = opnd;

                    if (state_q == ENT_A) begin
                        if (is_op) begin
                            op_sel_d = Pos[2:0];
                            b_d      = '0;
                            n_d      = '0;
                            state_d  = ENT_B;
                        end else if (Pos == K_ROOT) begin
                            op_sel_d = OP_ROOT;
                            b_d      = '0;
                            state_d  = ESPERA;
                        end
                    end else begin
                        // Operator can only be changed before B is typed
                        if (is_op && n_q == '0) begin
                            op_sel_d = Pos[2:0];
                        end else if (Pos == K_EQ && n_q != '0) begin
                            state_d = ESPERA;
                        end
                    end
                end
                RESULT: begin
                    if (is_dig) begin
                        a_d     = dig_w;
                        n_d     = NW'(1);
                        err_d   = 1'b0;
                        state_d = ENT_A;
                    end else if (Pos == K_BSP || Pos == K_CE) begin
                        a_d     = '0;
                        n_d     = '0;
                        err_d   = 1'b0;
                        state_d = ENT_A;
`ifdef RESULT_CHAIN_EN
                    end else if (is_op && !err_q) begin
                        // A is full (all DIGITS used); counter now tracks B
                        a_d      = res_q;
                        op_sel_d = Pos[2:0];
                        b_d      = '0;
                        n_d      = '0;
                        state_d  = ENT_B;
                    end else if (Pos == K_ROOT && !err_q) begin
                        a_d      = res_q;
                        n_d      = NW'(DIGITS);
                        op_sel_d = OP_ROOT;
                        b_d      = '0;
                        state_d  = ESPERA;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ENT_A;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            n_q      <= '0;
            op_sel_q <= '0;
            err_q    <= 1'b0;
            bs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            n_q      <= n_d;
            op_sel_q <= op_sel_d;
            err_q    <= err_d;
            bs_q     <= bs_d;
        end
    end

    // Outputs are straight from registers, except the display select mux
    always_comb begin
        op_a     = a_q;
        op_b     = b_q;
        op_sel   = op_sel_q;
        calc_req = (state_q == ESPERA);
        err      = err_q;
        estado   = state_q;
        case (state_q)
            ENT_B:   disp_val = b_q;
            RESULT:  disp_val = res_q;
            default: disp_val = a_q;
        endcase
    end

endmodule

// File: tb/tb_captura_teclas.sv
// Directed bench for captura_teclas: digit entry, edge detection, the
// operator/equals flow, ALU handshake, AC abort and result chaining.
module tb_captura_teclas;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Pos;
    logic        BS;
    logic [15:0] result;
    logic        calc_ack;
    logic        calc_err;
    logic [15:0] op_a, op_b, disp_val;
    logic [2:0]  op_sel;
    logic        calc_req, err;
    logic [1:0]  estado;

    int total = 0;
    int bad   = 0;

    captura_teclas dut (
        .clk(clk), .rst(rst), .Pos(Pos), .BS(BS), .result(result),
        .calc_ack(calc_ack), .calc_err(calc_err), .op_a(op_a), .op_b(op_b),
        .op_sel(op_sel), .calc_req(calc_req), .disp_val(disp_val),
        .err(err), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One press: BS high for one clock then released; returns at a negedge
    task automatic press(input logic [4:0] p);
        @(negedge clk); Pos = p; BS = 1'b1;
        @(negedge clk); BS = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack(input logic [15:0] r, input logic e);
        @(negedge clk); result = r; calc_err = e; calc_ack = 1'b1;
        @(negedge clk); calc_ack = 1'b0; calc_err = 1'b0;
    endtask

    initial begin
        rst = 1'b0; Pos = 5'd0; BS = 1'b0;
        result = 16'h0; calc_ack = 1'b0; calc_err = 1'b0;

        // Reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_disp", disp_val, 16'h0);
        chk("rst_opa", op_a, 16'h0);
        chk("rst_opb", op_b, 16'h0);
        chk("rst_opsel", op_sel, 3'd0);
        chk("rst_req", calc_req, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_estado", estado, 2'd0);

        press(5'd21); press(5'd22);
        chk("digits_12", disp_val, 16'h0012);

        // Held BS appends one digit
        @(negedge clk); Pos = 5'd23; BS = 1'b1;
        repeat (10) @(negedge clk);
        BS = 1'b0; @(negedge clk);
        chk("hold_one", disp_val, 16'h0123);

        // Fifth digit dropped
        press(5'd19);
        chk("ac_disp", disp_val, 16'h0);
        press(5'd21); press(5'd22); press(5'd23); press(5'd15); press(5'd16);
        chk("max_digits", disp_val, 16'h1234);
        press(5'd14);
        chk("bsp_a", disp_val, 16'h0123);
        press(5'd25);
        chk("point_ign", disp_val, 16'h0123);
        press(5'd24); press(5'd14);
        chk("bsp_at_zero", disp_val, 16'h0);
        press(5'd4);
        chk("eq_in_a", estado, 2'd0);

        // 7 + 5 =
        press(5'd18); press(5'd0);
        chk("plus_estado", estado, 2'd1);
        press(5'd16); press(5'd4);
        repeat (5) @(negedge clk);
        chk("req_held", calc_req, 1'b1);
        chk("esp_opa", op_a, 16'h7);
        chk("esp_opb", op_b, 16'h5);
        chk("esp_opsel", op_sel, 3'd0);
        chk("esp_estado", estado, 2'd2);
        ack(16'h000C, 1'b0);
        chk("res_estado", estado, 2'd3);
        chk("res_disp", disp_val, 16'h000C);
        chk("res_req", calc_req, 1'b0);

        // Operator on a shown result
        press(5'd2);
`ifdef RESULT_CHAIN_EN
        chk("chain_estado", estado, 2'd1);
        chk("chain_opa", op_a, 16'h000C);
        chk("chain_opsel", op_sel, 3'd2);
`else
        chk("nochain_estado", estado, 2'd3);
        chk("nochain_disp", disp_val, 16'h000C);
`endif

        // B editing, operator replacement
        press(5'd19);
        press(5'd21); press(5'd0); press(5'd23); press(5'd8);
        chk("b_3f", disp_val, 16'h003F);
        press(5'd1);
        chk("op_locked", op_sel, 3'd0);
        press(5'd14);
        chk("b_bsp", disp_val, 16'h0003);
        press(5'd24);
        chk("b_ce", disp_val, 16'h0);
        press(5'd1);
        chk("op_replace", op_sel, 3'd1);
        press(5'd4);
        chk("eq_n0", estado, 2'd1);

        // Keys in ESPERA, AC abort, late ack
        press(5'd22); press(5'd4);
        chk("esp2", estado, 2'd2);
        press(5'd21);
        chk("esp_key_ign", disp_val, 16'h0001);
        chk("esp_key_st", estado, 2'd2);
        press(5'd19);
        chk("abort_req", calc_req, 1'b0);
        chk("abort_st", estado, 2'd0);
        chk("abort_disp", disp_val, 16'h0);
        ack(16'h0055, 1'b0);
        chk("late_ack_st", estado, 2'd0);
        chk("late_ack_disp", disp_val, 16'h0);

        // Divide by zero, error result, operator suppressed
        press(5'd10); press(5'd3); press(5'd20); press(5'd4);
        chk("div_opsel", op_sel, 3'd3);
        ack(16'h0000, 1'b1);
        chk("div_err", err, 1'b1);
        press(5'd0);
        chk("err_no_chain", estado, 2'd3);
        press(5'd16);
        chk("new_a_st", estado, 2'd0);
        chk("new_a_disp", disp_val, 16'h0005);
        chk("new_a_err", err, 1'b0);

        // Root from ENT_A
        press(5'd9);
        chk("root_st", estado, 2'd2);
        chk("root_opsel", op_sel, 3'd4);
        chk("root_opb", op_b, 16'h0);
        chk("root_opa", op_a, 16'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
